// File: rtl/tb_scoreboard_pkg.sv
// Shared types, default widths and the saturating-add helper for the in-order scoreboard.
package tb_scoreboard_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } sb_state_e;

   localparam int unsigned DefDataW      = 32;
   localparam int unsigned DefDepth      = 16;
   localparam int unsigned DefCntW       = 16;
   localparam int unsigned DefTimeoutCyc = 1024;

   // Widened sum so an add near the top of the range clamps instead of wrapping.
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] maxv);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum > {1'b0, maxv}) return maxv;
      return sum[31:0];
   endfunction

endpackage

// File: rtl/tb_sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry an extra MSB to tell full from empty.
module tb_sync_fifo #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 16,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       count
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic              do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count   = wr_ptr_q - rd_ptr_q;
   assign dout    = mem_q[rd_ptr_q[AW-1:0]];
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/tb_scoreboard.sv
// In-order scoreboard: buffers expected words, compares DUT words, reports a final verdict.
// Optional drain timeout is enabled by defining TB_SCOREBOARD_TIMEOUT_EN.
module tb_scoreboard
   import tb_scoreboard_pkg::*;
#(
   parameter int unsigned DATA_W      = DefDataW,
   parameter int unsigned DEPTH       = DefDepth,
   parameter int unsigned CNT_W       = DefCntW,
   parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
   input  logic              tb_clk,
   input  logic              tb_rst_n,
   input  logic              exp_valid,
   output logic              exp_ready,
   input  logic [DATA_W-1:0] exp_data,
   input  logic              act_valid,
   input  logic [DATA_W-1:0] act_data,
   input  logic              eot,
   output logic              mismatch,
   output logic [CNT_W-1:0]  pass_count,
   output logic [CNT_W-1:0]  fail_count,
   output logic [DATA_W-1:0] first_exp,
   output logic [DATA_W-1:0] first_act,
   output logic              err_underflow,
   output logic              done,
`ifdef TB_SCOREBOARD_TIMEOUT_EN
   output logic              err_timeout,
`endif
   output logic              passed
);

   localparam int unsigned AW     = $clog2(DEPTH);
   localparam logic [31:0] CntMax = 32'((64'd1 << CNT_W) - 64'd1);

   sb_state_e         state_q, state_d;
   logic              mismatch_q, mismatch_d;
   logic [CNT_W-1:0]  pass_q, pass_d, fail_q, fail_d;
   logic [DATA_W-1:0] fexp_q, fexp_d, fact_q, fact_d;
   logic              seen_q, seen_d, uf_q, uf_d;
   logic              full, empty, push, pop, flush, underflow, pass_evt, fail_evt, tmo_err;
   logic [AW:0]       count;
   logic [DATA_W-1:0] head;

   // Readiness comes from registered occupancy only, so a same-cycle pop never frees a slot.
   assign exp_ready = !full;
   assign push      = exp_valid && !full;
   assign pop       = act_valid && !empty;
   assign underflow = act_valid && empty;
   assign pass_evt  = pop && (head == act_data);
   assign fail_evt  = underflow || (pop && (head != act_data));

   tb_sync_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk  (tb_clk),
      .rst_n(tb_rst_n),
      .push (push),
      .pop  (pop),
      .flush(flush),
      .din  (exp_data),
      .dout (head),
      .full (full),
      .empty(empty),
      .count(count)
   );

`ifdef TB_SCOREBOARD_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          tmo_q, tmo_d;
   assign err_timeout = tmo_q;
   assign tmo_err     = tmo_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^32'(TIMEOUT_CYC);
   assign tmo_err        = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      mismatch_d = fail_evt;
      pass_d     = pass_q;
      fail_d     = fail_q;
      fexp_d     = fexp_q;
      fact_d     = fact_q;
      seen_d     = seen_q;
      uf_d       = uf_q || underflow;
      flush      = 1'b0;
`ifdef TB_SCOREBOARD_TIMEOUT_EN
      tmo_cnt_d  = '0;
      tmo_d      = tmo_q;
`endif
      if (pass_evt) pass_d = CNT_W'(sat_add(32'(pass_q), 32'd1, CntMax));
      if (fail_evt) begin
         fail_d = CNT_W'(sat_add(32'(fail_q), 32'd1, CntMax));
         if (!seen_q) begin
            seen_d = 1'b1;
            fexp_d = underflow ? '0 : head;
            fact_d = act_data;
         end
      end
      unique case (state_q)
         StIdle: begin
            if (eot) state_d = StDrain;
            else if (push || act_valid) state_d = StRun;
         end
         StRun: if (eot) state_d = StDrain;
         StDrain: begin
`ifdef TB_SCOREBOARD_TIMEOUT_EN
            if (!act_valid) tmo_cnt_d = tmo_cnt_q + TW'(1);
`endif
            if (empty && !act_valid && !push) begin
               state_d = StDone;
`ifdef TB_SCOREBOARD_TIMEOUT_EN
            end else if (!act_valid && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1))) begin
               // Leftover expected words each count as a failure.
               state_d = StDone;
               tmo_d   = 1'b1;
               flush   = 1'b1;
               fail_d  = CNT_W'(sat_add(32'(fail_q), 32'(count), CntMax));
`endif
            end
         end
         StDone: state_d = StDone;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge tb_clk or negedge tb_rst_n) begin
      if (!tb_rst_n) begin
         state_q    <= StIdle;
         mismatch_q <= 1'b0;
         pass_q     <= '0;
         fail_q     <= '0;
         fexp_q     <= '0;
         fact_q     <= '0;
         seen_q     <= 1'b0;
         uf_q       <= 1'b0;
`ifdef TB_SCOREBOARD_TIMEOUT_EN
         tmo_cnt_q  <= '0;
         tmo_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         mismatch_q <= mismatch_d;
         pass_q     <= pass_d;
         fail_q     <= fail_d;
         fexp_q     <= fexp_d;
         fact_q     <= fact_d;
         seen_q     <= seen_d;
         uf_q       <= uf_d;
`ifdef TB_SCOREBOARD_TIMEOUT_EN
         tmo_cnt_q  <= tmo_cnt_d;
         tmo_q      <= tmo_d;
`endif
      end
   end

   assign mismatch      = mismatch_q;
   assign pass_count    = pass_q;
   assign fail_count    = fail_q;
   assign first_exp     = fexp_q;
   assign first_act     = fact_q;
   assign err_underflow = uf_q;
   assign done          = (state_q == StDone);
   assign passed        = done && (fail_q == '0) && !uf_q && !tmo_err;

endmodule

// File: tb/tb_tb_scoreboard.sv
// Self-checking bench for tb_scoreboard: a queue-based reference model predicts every output.
module tb_tb_scoreboard;

   localparam int unsigned DATA_W      = 32;
   localparam int unsigned DEPTH       = 16;
   localparam int unsigned CNT_W       = 4;
   localparam int unsigned TIMEOUT_CYC = 8;
   localparam int          CntMax      = 15;

   logic              tb_clk = 1'b0;
   logic              tb_rst_n = 1'b0;
   logic              exp_valid = 1'b0, act_valid = 1'b0, eot = 1'b0;
   logic [DATA_W-1:0] exp_data = '0, act_data = '0;
   logic              exp_ready, mismatch, err_underflow, done, passed;
   logic [CNT_W-1:0]  pass_count, fail_count;
   logic [DATA_W-1:0] first_exp, first_act;
`ifdef TB_SCOREBOARD_TIMEOUT_EN
   logic              err_timeout;
`endif

   tb_scoreboard #(
      .DATA_W     (DATA_W),
      .DEPTH      (DEPTH),
      .CNT_W      (CNT_W),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .tb_clk       (tb_clk),
      .tb_rst_n     (tb_rst_n),
      .exp_valid    (exp_valid),
      .exp_ready    (exp_ready),
      .exp_data     (exp_data),
      .act_valid    (act_valid),
      .act_data     (act_data),
      .eot          (eot),
      .mismatch     (mismatch),
      .pass_count   (pass_count),
      .fail_count   (fail_count),
      .first_exp    (first_exp),
      .first_act    (first_act),
      .err_underflow(err_underflow),
      .done         (done),
`ifdef TB_SCOREBOARD_TIMEOUT_EN
      .err_timeout  (err_timeout),
`endif
      .passed       (passed)
   );

   always #5 tb_clk = ~tb_clk;

   int total = 0;
   int bad = 0;

   // Reference model state
   logic [DATA_W-1:0] mq[$];
   int                m_pass, m_fail, m_state, m_tc;
   bit                m_uf, m_seen, m_mis, m_tmo, any_mis;
   logic [DATA_W-1:0] m_fexp, m_fact;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic int sat(input int v);
      return (v > CntMax) ? CntMax : v;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_pass = 0; m_fail = 0; m_state = 0; m_tc = 0;
      m_uf = 0; m_seen = 0; m_mis = 0; m_tmo = 0; any_mis = 0;
      m_fexp = '0; m_fact = '0;
   endtask

   task automatic note_fail(input logic [DATA_W-1:0] e, input logic [DATA_W-1:0] a);
      m_fail = sat(m_fail + 1);
      m_mis  = 1;
      if (!m_seen) begin
         m_seen = 1; m_fexp = e; m_fact = a;
      end
   endtask

   task automatic check_all();
      check("exp_ready", exp_ready, mq.size() < DEPTH);
      check("mismatch", mismatch, m_mis);
      check("pass_count", pass_count, m_pass);
      check("fail_count", fail_count, m_fail);
      check("first_exp", first_exp, m_fexp);
      check("first_act", first_act, m_fact);
      check("err_underflow", err_underflow, m_uf);
      check("done", done, m_state == 3);
      check("passed", passed, (m_state == 3) && (m_fail == 0) && !m_uf && !m_tmo);
`ifdef TB_SCOREBOARD_TIMEOUT_EN
      check("err_timeout", err_timeout, m_tmo);
`endif
      if (mismatch) any_mis = 1;
   endtask

   // Advance the model by one clock using the currently driven inputs, then compare.
   task automatic step();
      int pre_size;
      bit was_empty, push_ok, timeout;
      logic [DATA_W-1:0] h;
      pre_size  = mq.size();
      was_empty = (pre_size == 0);
      push_ok   = exp_valid && (pre_size < DEPTH);
      timeout   = 0;
      m_mis     = 0;
      if (act_valid) begin
         if (was_empty) begin
            m_uf = 1;
            note_fail('0, act_data);
         end else begin
            h = mq.pop_front();
            if (h == act_data) m_pass = sat(m_pass + 1);
            else note_fail(h, act_data);
         end
      end
      if (push_ok) mq.push_back(exp_data);
      case (m_state)
         0: if (eot) m_state = 2; else if (push_ok || act_valid) m_state = 1;
         1: if (eot) m_state = 2;
         2: begin
            if (was_empty && !act_valid && !push_ok) m_state = 3;
`ifdef TB_SCOREBOARD_TIMEOUT_EN
            else if (!act_valid && m_tc == TIMEOUT_CYC - 1) timeout = 1;
            m_tc = act_valid ? 0 : m_tc + 1;
`endif
         end
         default: ;
      endcase
      if (timeout) begin
         m_state = 3; m_tmo = 1; m_fail = sat(m_fail + pre_size); mq.delete();
      end
      if (m_state != 2) m_tc = 0;
      @(posedge tb_clk);
      #1;
      check_all();
   endtask

   task automatic drive(input bit ev, input logic [DATA_W-1:0] ed, input bit av,
                        input logic [DATA_W-1:0] ad, input bit e);
      exp_valid = ev; exp_data = ed; act_valid = av; act_data = ad; eot = e;
      step();
      exp_valid = 0; act_valid = 0; eot = 0;
   endtask

   task automatic do_reset();
      tb_rst_n = 0;
      model_reset();
      @(posedge tb_clk);
      #1;
      tb_rst_n = 1;
      step();
   endtask

   initial begin
      int cyc;
      model_reset();
      @(posedge tb_clk);
      #1;
      check_all();
      tb_rst_n = 1;
      step();

      // Three matching words, then end of test.
      drive(1, 32'h11, 0, 0, 0);
      drive(1, 32'h22, 0, 0, 0);
      drive(1, 32'h33, 0, 0, 0);
      drive(0, 0, 1, 32'h11, 0);
      drive(0, 0, 1, 32'h22, 0);
      drive(0, 0, 1, 32'h33, 0);
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0);
      check("t1_pass", pass_count, 3);
      check("t1_fail", fail_count, 0);
      check("t1_done", done, 1);
      check("t1_passed", passed, 1);
      check("t1_no_mis", any_mis, 0);

      // Single mismatch.
      do_reset();
      drive(1, 32'hA5, 0, 0, 0);
      drive(0, 0, 1, 32'h5A, 0);
      check("t2_mis", mismatch, 1);
      check("t2_fexp", first_exp, 32'hA5);
      check("t2_fact", first_act, 32'h5A);
      drive(0, 0, 0, 0, 1);
      check("t2_pulse", mismatch, 0);
      drive(0, 0, 0, 0, 0);
      check("t2_done", done, 1);
      check("t2_passed", passed, 0);

      // Act while pushing to an empty FIFO: underflow, word still queued.
      do_reset();
      drive(1, 32'h77, 1, 32'h77, 0);
      check("t3_uf", err_underflow, 1);
      check("t3_fail", fail_count, 1);
      check("t3_fexp", first_exp, 0);
      drive(0, 0, 1, 32'h77, 0);
      check("t3_held", pass_count, 1);

      // Fill to full, hold off a 17th word, then drain across the pointer wrap.
      do_reset();
      for (int i = 0; i < 16; i++) drive(1, 32'h100 + i, 0, 0, 0);
      check("t4_full", exp_ready, 0);
      drive(1, 32'hDEAD, 0, 0, 0);
      check("t4_held", exp_ready, 0);
      drive(0, 0, 1, 32'h100, 0);
      check("t4_ready", exp_ready, 1);
      drive(1, 32'h200, 1, 32'h101, 0);
      drive(1, 32'h201, 0, 0, 0);
      for (int i = 2; i < 16; i++) drive(0, 0, 1, 32'h100 + i, 0);
      drive(0, 0, 1, 32'h200, 0);
      drive(0, 0, 1, 32'h201, 0);
      check("t4_pass_sat", pass_count, CntMax);
      check("t4_fail", fail_count, 0);

`ifdef TB_SCOREBOARD_TIMEOUT_EN
      // Drain timeout with two leftover words.
      do_reset();
      drive(1, 32'h1, 0, 0, 0);
      drive(1, 32'h2, 0, 0, 0);
      drive(0, 0, 0, 0, 1);
      cyc = 0;
      while (!done && cyc < 40) begin
         drive(0, 0, 0, 0, 0);
         cyc++;
      end
      check("t5_cycles", cyc, TIMEOUT_CYC);
      check("t5_tmo", err_timeout, 1);
      check("t5_fail", fail_count, 2);
      check("t5_passed", passed, 0);
`endif

      // Asynchronous reset mid-run with five entries queued.
      do_reset();
      for (int i = 0; i < 5; i++) drive(1, 32'h300 + i, 0, 0, 0);
      drive(0, 0, 1, 32'h999, 0);
      #2;
      tb_rst_n = 0;
      #1;
      check("t6_ready", exp_ready, 1);
      check("t6_fail", fail_count, 0);
      check("t6_pass", pass_count, 0);
      check("t6_mis", mismatch, 0);
      check("t6_fexp", first_exp, 0);
      check("t6_fact", first_act, 0);
      check("t6_uf", err_underflow, 0);
      check("t6_done", done, 0);
      model_reset();
      @(posedge tb_clk);
      #1;
      tb_rst_n = 1;
      step();
      drive(0, 0, 1, 32'h300, 0);
      check("t6_empty", err_underflow, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
